// File: rtl/mult_seq_ctrl.sv
// 6502 bus-mapped controller around an 8x8 unsigned shift-add multiplier.
// Define MULTSEQ_IRQ_EN to build the registered active-low interrupt output.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          AUTO_START = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  input  logic       rwb_i,
  input  logic [2:0] addr_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       dout_oe_o,
  output logic       irqb_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d, prod_q, prod_d, acc_sum;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   done_q, done_d, err_q, err_d;
  logic                   irq_en;

  logic wr, rd, a_wr, b_wr, ctrl_wr, stat_rd, start_req;
  logic busy, last, launch, finish;

  assign wr        = ce_i & ~rwb_i;
  assign rd        = ce_i & rwb_i;
  assign a_wr      = wr && (addr_i == 3'd0);
  assign b_wr      = wr && (addr_i == 3'd1);
  assign ctrl_wr   = wr && (addr_i == 3'd2);
  assign stat_rd   = rd && (addr_i == 3'd2);
  assign start_req = (ctrl_wr & din_i[0]) | (AUTO_START & b_wr);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_req) state_d = StRun;
      StRun:   if (last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state_q == StRun);
    last   = (cnt_q == CntW'(WIDTH - 1));
    launch = (state_q == StIdle) && start_req;
    finish = busy && last;
  end

  assign acc_sum = acc_q + (mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0);

  always_comb begin
    a_d      = a_wr ? din_i : a_q;
    b_d      = b_wr ? din_i : b_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    if (launch) begin
      // An auto-start B write must multiply by the value being written.
      mcand_d  = a_q;
      mplier_d = b_wr ? din_i : b_q;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (busy) begin
      acc_d    = acc_sum;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if (finish) prod_d = acc_sum;
    end

    done_d = done_q;
    if (launch || stat_rd) done_d = 1'b0;
    if (finish) done_d = 1'b1;

    err_d = err_q;
    if (ctrl_wr && din_i[7]) err_d = 1'b0;
    if (start_req && busy) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef MULTSEQ_IRQ_EN
  logic irq_en_q, irqb_q;

  // irqb lags DONE by one edge, so it releases the edge after the clearing read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en_q <= 1'b0;
      irqb_q   <= 1'b1;
    end else begin
      if (ctrl_wr) irq_en_q <= din_i[1];
      irqb_q <= ~(done_q & irq_en_q);
    end
  end

  assign irq_en = irq_en_q;
  assign irqb_o = irqb_q;
`else
  assign irq_en = 1'b0;
  assign irqb_o = 1'b1;
`endif

  always_comb begin
    dout_oe_o = rd;
    unique case (addr_i)
      3'd0:    dout_o = a_q;
      3'd1:    dout_o = b_q;
      3'd2:    dout_o = {4'b0000, irq_en, err_q, done_q, busy};
      3'd3:    dout_o = prod_q[7:0];
      3'd4:    dout_o = prod_q[15:8];
      default: dout_o = 8'h00;
    endcase
  end

endmodule
